// File: rtl/pixie_video_back_end_if.sv
// Frame-buffer read port and video/sync outputs of the Pixie display back end.
// The back end is the master; the frame buffer and video scaler sit on the slave side.
interface pixie_video_back_end_if;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       video;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       frame_start;

    modport master (
        output rd_addr,
        input  rd_data,
        output video,
        output hsync,
        output vsync,
        output hblank,
        output vblank,
        output frame_start
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  video,
        input  hsync,
        input  vsync,
        input  hblank,
        input  vblank,
        input  frame_start
    );
endinterface

// File: rtl/pixie_video_back_end.sv
// CDP1861 (Pixie) display back end: frame-buffer fetch, MSB-first pixel serialiser, sync/blank timing.
// Define PIXIE_BORDER_EN to add the border_on input that drives video outside the active window.
module pixie_video_back_end #(
    parameter int H_TOTAL      = 112,
    parameter int H_ACT_START  = 16,
    parameter int H_SYNC_START = 96,
    parameter int H_SYNC_LEN   = 8,
    parameter int V_TOTAL      = 262,
    parameter int V_ACT_START  = 80,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic disp_on,
`ifdef PIXIE_BORDER_EN
    input  logic border_on,
`endif
    pixie_video_back_end_if.master vid
);

    localparam int H_W   = $clog2(H_TOTAL);
    localparam int V_W   = $clog2(V_TOTAL);
    localparam int H_ACT = 64;
    localparam int V_ACT = 128;

    localparam logic [H_W-1:0] H_LAST        = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_FIRST   = H_W'(H_ACT_START);
    localparam logic [H_W-1:0] H_ACT_LAST    = H_W'(H_ACT_START + H_ACT - 1);
    localparam logic [H_W-1:0] H_FETCH_FIRST = H_W'(H_ACT_START - 1);
    localparam logic [H_W-1:0] H_FETCH_LAST  = H_W'(H_ACT_START + H_ACT - 9);
    localparam logic [H_W-1:0] H_SYNC_FIRST  = H_W'(H_SYNC_START);
    localparam logic [H_W-1:0] H_SYNC_LAST   = H_W'(H_SYNC_START + H_SYNC_LEN - 1);

    localparam logic [V_W-1:0] V_LAST        = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_FIRST   = V_W'(V_ACT_START);
    localparam logic [V_W-1:0] V_ACT_LAST    = V_W'(V_ACT_START + V_ACT - 1);
    localparam logic [V_W-1:0] V_SYNC_FIRST  = V_W'(V_SYNC_START);
    localparam logic [V_W-1:0] V_SYNC_LAST   = V_W'(V_SYNC_START + V_SYNC_LEN - 1);

    logic [H_W-1:0] h_reg, h_next;
    logic [V_W-1:0] v_reg, v_next;
    logic [7:0]     shift_reg, shift_next;
    logic [9:0]     rd_addr_reg, rd_addr_next;
    logic           frame_en_reg, frame_en_next;
    logic           video_reg, video_next;
    logic           hsync_reg, vsync_reg;
    logic           hblank_reg, vblank_reg;
    logic           frame_start_reg;

    logic           h_act, v_act, h_sync, v_sync;
    logic           at_origin, fetch, load;
    logic [5:0]     fetch_ofs;
    logic [2:0]     pix_ofs;
    logic [6:0]     line;

    // Position decode for the current counter state.
    always_comb begin
        h_act     = (h_reg >= H_ACT_FIRST) && (h_reg <= H_ACT_LAST);
        v_act     = (v_reg >= V_ACT_FIRST) && (v_reg <= V_ACT_LAST);
        h_sync    = (h_reg >= H_SYNC_FIRST) && (h_reg <= H_SYNC_LAST);
        v_sync    = (v_reg >= V_SYNC_FIRST) && (v_reg <= V_SYNC_LAST);
        at_origin = (h_reg == '0) && (v_reg == '0);
        fetch_ofs = 6'(h_reg - H_FETCH_FIRST);
        pix_ofs   = 3'(h_reg - H_ACT_FIRST);
        line      = 7'(v_reg - V_ACT_FIRST);
        fetch     = v_act && (h_reg >= H_FETCH_FIRST) && (h_reg <= H_FETCH_LAST)
                    && (fetch_ofs[2:0] == 3'd0);
        load      = h_act && v_act && (pix_ofs == 3'd0);
    end

    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + V_W'(1);
        end else begin
            h_next = h_reg + H_W'(1);
        end
    end

    // The byte fetched one enable earlier is loaded on the first column of each
    // 8-pixel group, so its MSB reaches video in step with the blanking flags.
    always_comb begin
        shift_next    = shift_reg;
        rd_addr_next  = rd_addr_reg;
        frame_en_next = frame_en_reg;
        video_next    = 1'b0;

        if (h_act && v_act) begin
            shift_next = load ? vid.rd_data : {shift_reg[6:0], 1'b0};
        end
        if (fetch) begin
            rd_addr_next = {line, fetch_ofs[5:3]};
        end
        if (at_origin) begin
            frame_en_next = disp_on;
        end

        if (h_act && v_act) begin
            video_next = frame_en_reg & shift_next[7];
        end
`ifdef PIXIE_BORDER_EN
        else if (!h_sync && !v_sync) begin
            video_next = border_on;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_reg        <= '0;
            v_reg        <= '0;
            shift_reg    <= '0;
            rd_addr_reg  <= '0;
            frame_en_reg <= 1'b0;
            video_reg    <= 1'b0;
            hsync_reg    <= 1'b0;
            vsync_reg    <= 1'b0;
            hblank_reg   <= 1'b1;
            vblank_reg   <= 1'b1;
        end else if (clk_enable) begin
            h_reg        <= h_next;
            v_reg        <= v_next;
            shift_reg    <= shift_next;
            rd_addr_reg  <= rd_addr_next;
            frame_en_reg <= frame_en_next;
            video_reg    <= video_next;
            hsync_reg    <= h_sync;
            vsync_reg    <= v_sync;
            hblank_reg   <= !h_act;
            vblank_reg   <= !v_act;
        end
    end

    // Single-clk pulse regardless of enable spacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= clk_enable && at_origin;
        end
    end

    assign vid.rd_addr     = rd_addr_reg;
    assign vid.video       = video_reg;
    assign vid.hsync       = hsync_reg;
    assign vid.vsync       = vsync_reg;
    assign vid.hblank      = hblank_reg;
    assign vid.vblank      = vblank_reg;
    assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_pixie_video_back_end.sv
// Directed self-checking bench for pixie_video_back_end: frame timing, pixel fetch/serialisation,
// disp_on framing, sparse clock enables and mid-frame reset.
module tb_pixie_video_back_end;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic clk_enable = 1'b0;
    logic disp_on    = 1'b0;
    logic border_on  = 1'b1;

`ifdef PIXIE_BORDER_EN
    localparam bit BORDER_BUILD = 1'b1;
`else
    localparam bit BORDER_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    pixie_video_back_end_if vif();

    logic [7:0] mem [0:1023];
    assign vif.rd_data = mem[vif.rd_addr];

    pixie_video_back_end dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .disp_on    (disp_on),
`ifdef PIXIE_BORDER_EN
        .border_on  (border_on),
`endif
        .vid        (vif)
    );

    int tests_run = 0;
    int failed    = 0;

    // Reference position/state advanced once per enable.
    int         h_m = 0;
    int         v_m = 0;
    int         last_h = 0;
    int         last_v = 0;
    logic       fe_m = 1'b0;
    logic [9:0] exp_rd_addr = '0;
    logic [4:0] exp_vec = 5'b00011;
    logic       exp_fs = 1'b0;

    // {video, hsync, vsync, hblank, vblank} for counter position (h, v).
    function automatic logic [4:0] exp_out(int h, int v, logic fe);
        logic       ha, va, hs, vs, pix;
        logic [7:0] b;
        ha  = (h >= 16) && (h <= 79);
        va  = (v >= 80) && (v <= 207);
        hs  = (h >= 96) && (h <= 103);
        vs  = (v >= 240) && (v <= 243);
        pix = 1'b0;
        if (ha && va) begin
            b   = mem[(v - 80) * 8 + (h - 16) / 8];
            pix = fe & b[7 - ((h - 16) % 8)];
        end else begin
            pix = BORDER_BUILD & border_on & ~hs & ~vs;
        end
        return {pix, hs, vs, ~ha, ~va};
    endfunction

    function automatic logic [15:0] observed();
        return {vif.video, vif.hsync, vif.vsync, vif.hblank, vif.vblank, vif.rd_addr, vif.frame_start};
    endfunction

    function automatic logic [15:0] expected();
        return {exp_vec, exp_rd_addr, exp_fs};
    endfunction

    task automatic step(input logic en);
        clk_enable = en;
        @(posedge clk);
        #1;
        exp_fs = 1'b0;
        if (reset) begin
            h_m = 0; v_m = 0; fe_m = 1'b0;
            exp_rd_addr = '0;
            exp_vec = 5'b00011;
        end else if (en) begin
            last_h = h_m;
            last_v = v_m;
            if (h_m == 0 && v_m == 0) begin
                fe_m   = disp_on;
                exp_fs = 1'b1;
            end
            if (v_m >= 80 && v_m <= 207 && h_m >= 15 && h_m <= 71 && (h_m - 15) % 8 == 0)
                exp_rd_addr = 10'((v_m - 80) * 8 + (h_m - 15) / 8);
            exp_vec = exp_out(h_m, v_m, fe_m);
            h_m++;
            if (h_m == 112) begin
                h_m = 0;
                v_m++;
                if (v_m == 262) v_m = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        disp_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            tests_run++;
            if (observed() !== 16'b00011_0000000000_0) begin
                failed++;
                $display("FAIL reset clk=%0d got %b required %b", i, observed(), 16'b00011_0000000000_0);
            end
        end
        reset = 1'b0;
    endtask

    // Frame 1: only bytes 0 and 1023 have a lit pixel.
    task automatic test_single_pixels();
        int ones = 0, hs_n = 0, vs_n = 0, fs_n = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]    = 8'h80;
        mem[1023] = 8'h01;
        for (int i = 0; i < 112 * 262; i++) begin
            step(1'b1);
            tests_run++;
            if (observed() !== expected()) begin
                failed++;
                $display("FAIL single_pixels h=%0d v=%0d got %b required %b", last_h, last_v, observed(), expected());
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
            if (vif.hsync) hs_n++;
            if (vif.vsync) vs_n++;
            if (vif.frame_start) fs_n++;
        end
        tests_run++;
        if (ones !== 2 || hs_n !== 2096 || vs_n !== 448 || fs_n !== 1) begin
            failed++;
            $display("FAIL frame_counts got lit=%0d hs=%0d vs=%0d fs=%0d required 2/2096/448/1", ones, hs_n, vs_n, fs_n);
        end
    endtask

    // Frame 2, lines 0..85: 0xA5 everywhere.
    task automatic test_pattern_a5();
        int ones = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
        for (int i = 0; i < 112 * 86; i++) begin
            step(1'b1);
            tests_run++;
            if (observed() !== expected()) begin
                failed++;
                $display("FAIL pattern_a5 h=%0d v=%0d got %b required %b", last_h, last_v, observed(), expected());
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
        end
        tests_run++;
        if (vif.rd_addr !== 10'd47 || ones !== 192) begin
            failed++;
            $display("FAIL a5_summary got addr=%0d lit=%0d required 47/192", vif.rd_addr, ones);
        end
    endtask

    // Frame 2, lines 86..91 with an enable every third clk; outputs must hold in between.
    task automatic test_enable_gap();
        int ones = 0;
        for (int i = 0; i < 112 * 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                step(j == 2);
                tests_run++;
                if (observed() !== expected()) begin
                    failed++;
                    $display("FAIL enable_gap h=%0d v=%0d slot=%0d got %b required %b", last_h, last_v, j, observed(), expected());
                end
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
        end
        tests_run++;
        if (vif.rd_addr !== 10'd95 || ones !== 192) begin
            failed++;
            $display("FAIL gap_summary got addr=%0d lit=%0d required 95/192", vif.rd_addr, ones);
        end
    endtask

    // Frame 2, lines 92..261: disp_on drops at line 150 without affecting this frame.
    task automatic test_disp_on_drop();
        int ones = 0;
        for (int i = 0; i < 112 * 170; i++) begin
            if (v_m == 150 && h_m == 0) disp_on = 1'b0;
            step(1'b1);
            tests_run++;
            if (observed() !== expected()) begin
                failed++;
                $display("FAIL disp_on_drop h=%0d v=%0d got %b required %b", last_h, last_v, observed(), expected());
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
        end
        tests_run++;
        if (ones !== 3712) begin
            failed++;
            $display("FAIL drop_summary got lit=%0d required 3712", ones);
        end
    endtask

    // Frame 3, lines 0..82: display off, timing unchanged.
    task automatic test_disp_off();
        int ones = 0, hs_n = 0, fs_n = 0;
        for (int i = 0; i < 112 * 83; i++) begin
            step(1'b1);
            tests_run++;
            if (observed() !== expected()) begin
                failed++;
                $display("FAIL disp_off h=%0d v=%0d got %b required %b", last_h, last_v, observed(), expected());
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
            if (vif.hsync) hs_n++;
            if (vif.frame_start) fs_n++;
        end
        tests_run++;
        if (ones !== 0 || hs_n !== 664 || fs_n !== 1) begin
            failed++;
            $display("FAIL off_summary got lit=%0d hs=%0d fs=%0d required 0/664/1", ones, hs_n, fs_n);
        end
    endtask

    // Reset for one clk at h=50, v=100, then restart from the origin.
    task automatic test_reset_mid();
        int ones = 0, fs_n = 0;
        for (int i = 0; i < 112 * 17 + 50; i++) step(1'b1);
        disp_on = 1'b1;
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        tests_run++;
        if (observed() !== 16'b00011_0000000000_0) begin
            failed++;
            $display("FAIL reset_mid got %b required %b", observed(), 16'b00011_0000000000_0);
        end
        for (int i = 0; i < 112 * 82; i++) begin
            step(1'b1);
            tests_run++;
            if (observed() !== expected()) begin
                failed++;
                $display("FAIL after_reset h=%0d v=%0d got %b required %b", last_h, last_v, observed(), expected());
            end
            if (i == 0) begin
                tests_run++;
                if (vif.frame_start !== 1'b1 || vif.hblank !== 1'b1 || vif.hsync !== 1'b0) begin
                    failed++;
                    $display("FAIL restart_origin got fs=%b hb=%b hs=%b required 1/1/0", vif.frame_start, vif.hblank, vif.hsync);
                end
            end
            if (vif.video && !vif.hblank && !vif.vblank) ones++;
            if (vif.frame_start) fs_n++;
        end
        tests_run++;
        if (ones !== 64 || fs_n !== 1) begin
            failed++;
            $display("FAIL restart_summary got lit=%0d fs=%0d required 64/1", ones, fs_n);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixels();
        test_pattern_a5();
        test_enable_gap();
        test_disp_on_drop();
        test_disp_off();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
